rtc_hms_counter: RTL and testbench
==================================

# rtc_hms_counter

Time-of-day counter that consumes the 1 Hz square wave produced by `clk_div_1hz` and maintains hours, minutes and seconds as packed BCD for display drivers. It detects rising edges of `newclk` in the `clk` domain rather than clocking flops from `newclk`. It also supports count enable, a validated BCD time load, and one-cycle event pulses for seconds and day rollover.

## Interface
- `RST_HH`, default 8'h00: BCD hours value loaded on reset; must be 00–23.
- `RST_MM`, default 8'h00: BCD minutes value loaded on reset; must be 00–59.
- `RST_SS`, default 8'h00: BCD seconds value loaded on reset; must be 00–59.
- `clk`  in  1  system clock, the same clock that drives `clk_div_1hz`.
- `rst_n`  in  1  reset, synchronous and active-low.
- `newclk`  in  1  1 Hz square wave from `clk_div_1hz`, already synchronous to `clk`.
- `run`  in  1  count enable; 1 = advance on each `newclk` rising edge.
- `load`  in  1  one-cycle request to load `load_hh`, `load_mm` and `load_ss`.
- `load_hh`  in  8  BCD hours to load.
- `load_mm`  in  8  BCD minutes to load.
- `load_ss`  in  8  BCD seconds to load.
- `hh_bcd`  out  8  hours in BCD, 00–23 (`[7:4]` tens, `[3:0]` units).
- `mm_bcd`  out  8  minutes in BCD, 00–59.
- `ss_bcd`  out  8  seconds in BCD, 00–59.
- `sec_tick`  out  1  one-cycle pulse on every counted second.
- `day_wrap`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 transition.
- `load_err`  out  1  one-cycle pulse when a load request is rejected.

## Operation
- **Edge detect**
  - Register `nc_d` samples `newclk` every cycle, independent of `run` and `load`.
  - `rise = newclk & ~nc_d`.
- **Counter structure**
  - Six BCD digit registers: s_lo (0–9), s_hi (0–5), m_lo (0–9), m_hi (0–5), h_lo (0–9), h_hi (0–2).
  - No binary-to-BCD conversion is used.
- **Advance** occurs when `rise & run & ~load`:
  - s_lo increments; 9 → 0 carries into s_hi.
  - s_hi 5 → 0 with carry increments m_lo; the minutes digits use the same rules.
  - m_hi 5 → 0 with carry increments the hours.
  - Hours digits: h_lo 9 → 0 carries into h_hi, except that 23 → 00 is forced.
  - `sec_tick` = 1 on every advance.
  - `day_wrap` = 1 only when the advance starts from 23:59:59.
- **Load** (`load` = 1), with priority over advance:
  - Valid when every nibble is ≤ 9, `load_ss[7:4]` ≤ 5, `load_mm[7:4]` ≤ 5, and `load_hh` ≤ 8'h23.
  - Valid: all digits take the load values. `sec_tick` = 0 and `day_wrap` = 0.
  - Invalid: time is unchanged and `load_err` = 1.
  - In both cases, a `rise` in the same cycle is discarded and not deferred.
  - Load works regardless of `run`.
- **`run` = 0**: time holds; edges seen while stopped are lost, not queued.
- **Reset** (`rst_n` = 0 at a `clk` edge), overrides everything, including mid-count:
  - `hh_bcd`/`mm_bcd`/`ss_bcd` = `RST_HH`/`RST_MM`/`RST_SS`.
  - `sec_tick`, `day_wrap`, `load_err` and `nc_d` = 0.
  - The first cycle after reset cannot produce a false `rise` if `newclk` is low. If `newclk` is already high, one `rise` is permitted.
- **State:** free-running counter. There is no FSM beyond the running (`run`) and holding behaviour.

## Timing
- All outputs are registered.
- Advance latency:
  - `newclk` first sampled high at edge k gives `rise` in cycle k.
  - At edge k+1, the new time and `sec_tick` are visible for exactly one cycle.
- Load latency: `load` sampled at edge k gives the new time, or `load_err`, visible from edge k+1.
- Pulse widths: `sec_tick`, `day_wrap` and `load_err` are each exactly 1 `clk` cycle.
- Rate limit: at most one advance per `newclk` period. A `newclk` held high for many cycles produces one advance.
- The carry chain resolves in a single cycle. 23:59:59 → 00:00:00 is a single-edge update.

## Test plan
The bench drives `newclk` directly with a short period (e.g. 8 cycles high, 8 cycles low) for simulation speed.
- **Reset and first second:** reset with defaults, `run` = 1, one `newclk` rise → `ss_bcd` = 8'h01 and a `sec_tick` pulse 1 cycle after the rise is sampled. All outputs read 00/0 during reset.
- **Minute/hour carry:** load 12:59:59, one rise → 13:00:00 with `day_wrap` = 0. Load 09:59:59, one rise → 10:00:00.
- **Day wrap:** load 23:59:59, one rise → 00:00:00, `day_wrap` = 1 and `sec_tick` = 1 for one cycle.
- **Invalid load:** from 05:10:20, load `hh` = 8'h24, or `mm` = 8'h60, or `ss` = 8'h1A → `load_err` pulse and time remains 05:10:20.
- **Load collides with rise:** load 08:00:00 in the same cycle as `rise` → 08:00:00 with no `sec_tick`. The next rise gives 08:00:01.
- **Hold and reset mid-run:**
  - `run` = 0 across 3 rises → time unchanged.
  - Assert `rst_n` = 0 at 14:33:07 → reset values on the next edge.
  - Resume counting from reset values after `rst_n` = 1.

Source files
------------

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter in packed BCD, advanced by rising edges of a 1 Hz square wave
// detected in the clk domain; supports run/hold, validated load and event pulses.
module rtc_hms_counter #(
  parameter logic [7:0] RST_HH = 8'h00,
  parameter logic [7:0] RST_MM = 8'h00,
  parameter logic [7:0] RST_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       newclk,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  logic [3:0] s_lo_q, s_hi_q, m_lo_q, m_hi_q, h_lo_q, h_hi_q;
  logic [3:0] s_lo_d, s_hi_d, m_lo_d, m_hi_d, h_lo_d, h_hi_d;
  logic       nc_q;
  logic       sec_tick_q, day_wrap_q, load_err_q;
  logic       sec_tick_d, day_wrap_d, load_err_d;

  logic rise, adv, load_ok;
  logic c_s0, c_s1, c_m0, c_m1, at_23h;

  assign rise = newclk & ~nc_q;
  assign adv  = rise & run & ~load;

  assign load_ok = (load_ss[3:0] <= 4'd9) && (load_ss[7:4] <= 4'd5) &&
                   (load_mm[3:0] <= 4'd9) && (load_mm[7:4] <= 4'd5) &&
                   (load_hh[3:0] <= 4'd9) && (load_hh <= 8'h23);

  // Ripple carries evaluated in one cycle so 23:59:59 -> 00:00:00 is a single update.
  assign c_s0   = (s_lo_q == 4'd9);
  assign c_s1   = c_s0 && (s_hi_q == 4'd5);
  assign c_m0   = c_s1 && (m_lo_q == 4'd9);
  assign c_m1   = c_m0 && (m_hi_q == 4'd5);
  assign at_23h = (h_hi_q == 4'd2) && (h_lo_q == 4'd3);

  always_comb begin
    s_lo_d     = s_lo_q;
    s_hi_d     = s_hi_q;
    m_lo_d     = m_lo_q;
    m_hi_d     = m_hi_q;
    h_lo_d     = h_lo_q;
    h_hi_d     = h_hi_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // A rise coinciding with a load is dropped, whether the load is accepted or not.
      if (load_ok) begin
        s_lo_d = load_ss[3:0];
        s_hi_d = load_ss[7:4];
        m_lo_d = load_mm[3:0];
        m_hi_d = load_mm[7:4];
        h_lo_d = load_hh[3:0];
        h_hi_d = load_hh[7:4];
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adv) begin
      sec_tick_d = 1'b1;
      day_wrap_d = c_m1 && at_23h;
      s_lo_d = c_s0 ? 4'd0 : s_lo_q + 4'd1;
      if (c_s0) s_hi_d = (s_hi_q == 4'd5) ? 4'd0 : s_hi_q + 4'd1;
      if (c_s1) m_lo_d = (m_lo_q == 4'd9) ? 4'd0 : m_lo_q + 4'd1;
      if (c_m0) m_hi_d = (m_hi_q == 4'd5) ? 4'd0 : m_hi_q + 4'd1;
      if (c_m1) begin
        if (at_23h) begin
          h_lo_d = 4'd0;
          h_hi_d = 4'd0;
        end else if (h_lo_q == 4'd9) begin
          h_lo_d = 4'd0;
          h_hi_d = h_hi_q + 4'd1;
        end else begin
          h_lo_d = h_lo_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_lo_q     <= RST_SS[3:0];
      s_hi_q     <= RST_SS[7:4];
      m_lo_q     <= RST_MM[3:0];
      m_hi_q     <= RST_MM[7:4];
      h_lo_q     <= RST_HH[3:0];
      h_hi_q     <= RST_HH[7:4];
      nc_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      s_lo_q     <= s_lo_d;
      s_hi_q     <= s_hi_d;
      m_lo_q     <= m_lo_d;
      m_hi_q     <= m_hi_d;
      h_lo_q     <= h_lo_d;
      h_hi_q     <= h_hi_d;
      nc_q       <= newclk;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign ss_bcd   = {s_hi_q, s_lo_q};
  assign mm_bcd   = {m_hi_q, m_lo_q};
  assign hh_bcd   = {h_hi_q, h_lo_q};
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed bench for rtc_hms_counter: drives newclk with a short 8-high/8-low period
// and compares outputs against hand-computed BCD times and pulses.
module tb_rtc_hms_counter;

  logic       clk;
  logic       rst_n;
  logic       newclk;
  logic       run;
  logic       load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       sec_tick, day_wrap, load_err;

  int checks = 0;
  int errors = 0;

  rtc_hms_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .newclk   (newclk),
    .run      (run),
    .load     (load),
    .load_hh  (load_hh),
    .load_mm  (load_mm),
    .load_ss  (load_ss),
    .hh_bcd   (hh_bcd),
    .mm_bcd   (mm_bcd),
    .ss_bcd   (ss_bcd),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] cur_time();
    return {hh_bcd, mm_bcd, ss_bcd};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic load_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    load = 1'b1; load_hh = hh; load_mm = mm; load_ss = ss;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One newclk period; reports time/pulses one cycle after the edge and
  // counts any further pulses over the rest of the period.
  task automatic newclk_period(output logic [23:0] t, output logic tick, output logic dw,
                               output int extra);
    extra = 0;
    newclk = 1'b1;
    @(negedge clk);
    t = cur_time(); tick = sec_tick; dw = day_wrap;
    for (int i = 0; i < 15; i++) begin
      if (i == 7) newclk = 1'b0;
      @(negedge clk);
      if (sec_tick || day_wrap) extra++;
    end
  endtask

  logic [23:0] t;
  logic        tk, dw;
  int          ex;
  logic [23:0] bad_vec [3];

  initial begin
    rst_n = 1'b0; run = 1'b1; newclk = 1'b0; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    bad_vec[0] = 24'h241020;
    bad_vec[1] = 24'h056020;
    bad_vec[2] = 24'h05101A;

    repeat (3) @(negedge clk);
    check_val("rst_time", cur_time(), 24'h000000);
    check_val("rst_pulses", {sec_tick, day_wrap, load_err}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    newclk_period(t, tk, dw, ex);
    check_val("first_sec_time", t, 24'h000001);
    check_val("first_sec_tick", tk, 1'b1);
    check_val("first_sec_ratelimit", ex, 0);

    load_time(8'h12, 8'h59, 8'h59);
    check_val("load_125959", cur_time(), 24'h125959);
    check_val("load_ok_pulses", {sec_tick, day_wrap, load_err}, 3'b000);
    newclk_period(t, tk, dw, ex);
    check_val("carry_13h_time", t, 24'h130000);
    check_val("carry_13h_dw", {tk, dw}, 2'b10);

    load_time(8'h09, 8'h59, 8'h59);
    newclk_period(t, tk, dw, ex);
    check_val("carry_10h_time", t, 24'h100000);

    load_time(8'h23, 8'h59, 8'h59);
    newclk_period(t, tk, dw, ex);
    check_val("daywrap_time", t, 24'h000000);
    check_val("daywrap_pulses", {tk, dw}, 2'b11);
    check_val("daywrap_width", ex, 0);

    load_time(8'h05, 8'h10, 8'h20);
    check_val("load_051020", cur_time(), 24'h051020);
    for (int i = 0; i < 3; i++) begin
      load = 1'b1;
      {load_hh, load_mm, load_ss} = bad_vec[i];
      @(negedge clk);
      load = 1'b0;
      check_val($sformatf("badload%0d_err", i), load_err, 1'b1);
      check_val($sformatf("badload%0d_time", i), cur_time(), 24'h051020);
      @(negedge clk);
      check_val($sformatf("badload%0d_errw", i), load_err, 1'b0);
    end

    // Load in the same cycle as the rising edge: the edge is discarded.
    newclk = 1'b1;
    load = 1'b1; load_hh = 8'h08; load_mm = 8'h00; load_ss = 8'h00;
    @(negedge clk);
    load = 1'b0;
    check_val("collide_time", cur_time(), 24'h080000);
    check_val("collide_tick", sec_tick, 1'b0);
    repeat (7) @(negedge clk);
    check_val("collide_nodefer", cur_time(), 24'h080000);
    newclk = 1'b0;
    repeat (8) @(negedge clk);
    newclk_period(t, tk, dw, ex);
    check_val("after_collide", t, 24'h080001);

    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      newclk_period(t, tk, dw, ex);
      check_val($sformatf("hold%0d_time", i), t, 24'h080001);
      check_val($sformatf("hold%0d_tick", i), tk, 1'b0);
    end
    run = 1'b1;

    load_time(8'h14, 8'h33, 8'h06);
    newclk_period(t, tk, dw, ex);
    check_val("pre_rst_time", t, 24'h143307);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrun_rst_time", cur_time(), 24'h000000);
    check_val("midrun_rst_pulses", {sec_tick, day_wrap, load_err}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle", cur_time(), 24'h000000);
    newclk_period(t, tk, dw, ex);
    check_val("resume_time", t, 24'h000001);
    check_val("resume_tick", tk, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
